// File: rtl/mt_pkg.sv
// Shared types and constants for the barrel-thread scheduler and its write-back delay line.
package mt_pkg;
  localparam int NUM_THREADS  = 4;
  localparam int BITS_THREADS = $clog2(NUM_THREADS);
  localparam int PERF_W       = 32;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    SWITCH = 2'd2
  } sched_state_t;
endpackage

// File: rtl/mt_wb_delay_line.sv
// Fixed-latency shift register carrying {valid, tid} from issue to write-back.
// any_valid reports whether any stage still holds a live instruction.
module mt_wb_delay_line #(
  parameter int DEPTH = 3,
  parameter int TID_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [TID_W-1:0] in_tid,
  output logic             out_valid,
  output logic [TID_W-1:0] out_tid,
  output logic             any_valid
);
  logic [DEPTH-1:0] valid_q;
  logic [TID_W-1:0] tid_q [DEPTH];

  // tid shifts every cycle, live or not, so the parity relation to the read slot always holds
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) tid_q[i] <= '0;
    end else begin
      valid_q[0] <= in_valid;
      tid_q[0]   <= in_tid;
      for (int i = 1; i < DEPTH; i++) begin
        valid_q[i] <= valid_q[i-1];
        tid_q[i]   <= tid_q[i-1];
      end
    end
  end

  assign out_valid = valid_q[DEPTH-1];
  assign out_tid   = tid_q[DEPTH-1];
  assign any_valid = |valid_q;
endmodule

// File: rtl/mt_thread_scheduler.sv
// Barrel-thread issue scheduler: free-running read slot, odd-latency write-back slot, group switch with drain.
// Optional performance counters are compiled in with MT_SCHED_PERF_EN.
module mt_thread_scheduler
  import mt_pkg::*;
#(
  parameter int WB_LATENCY = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [2*NUM_THREADS-1:0]  thread_en,
  input  logic                      stall,
  input  logic                      wb_we,
  input  logic                      switch_req,
  output logic                      switch_ack,
  output logic                      issue_valid,
  output logic [BITS_THREADS-1:0]   tid_read,
  output logic                      tgrp,
  output logic [BITS_THREADS-1:0]   tid_write,
  output logic                      write_enable,
  output logic                      wb_valid,
`ifdef MT_SCHED_PERF_EN
  input  logic                      perf_clr,
  output logic [PERF_W-1:0]         issue_cnt,
  output logic [PERF_W-1:0]         bubble_cnt,
`endif
  output sched_state_t              state_dbg
);
  // Even latency would put read and write on the same bank parity
  if ((WB_LATENCY < 1) || ((WB_LATENCY % 2) == 0)) begin : g_bad_latency
    $error("mt_thread_scheduler: WB_LATENCY must be odd and >= 1");
  end

  sched_state_t            state, state_next;
  logic [BITS_THREADS-1:0] slot_cnt;
  logic                    any_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt <= '0;
      state    <= RUN;
      tgrp     <= 1'b0;
    end else begin
      slot_cnt <= slot_cnt + 1'b1;
      state    <= state_next;
      if (state == SWITCH) tgrp <= ~tgrp;
    end
  end

  always_comb begin
    state_next = state;
    switch_ack = 1'b0;
    case (state)
      RUN:     if (switch_req) state_next = DRAIN;
      DRAIN:   if (!any_valid) state_next = SWITCH;
      SWITCH: begin
        switch_ack = 1'b1;
        state_next = RUN;
      end
      default: state_next = RUN;
    endcase
  end

  assign tid_read  = slot_cnt;
  assign state_dbg = state;

  // Issue is blocked in the cycle the switch request is taken; rst_n gating keeps outputs quiet in reset
  assign issue_valid = rst_n & (state == RUN) & ~switch_req & ~stall
                       & thread_en[{tgrp, tid_read}];

  mt_wb_delay_line #(
    .DEPTH (WB_LATENCY),
    .TID_W (BITS_THREADS)
  ) u_delay (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (issue_valid),
    .in_tid    (tid_read),
    .out_valid (wb_valid),
    .out_tid   (tid_write),
    .any_valid (any_valid)
  );

  assign write_enable = wb_valid & wb_we;

`ifdef MT_SCHED_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_cnt  <= '0;
      bubble_cnt <= '0;
    end else if (perf_clr) begin
      issue_cnt  <= '0;
      bubble_cnt <= '0;
    end else if (issue_valid) begin
      if (issue_cnt != '1) issue_cnt <= issue_cnt + 1'b1;
    end else begin
      if (bubble_cnt != '1) bubble_cnt <= bubble_cnt + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_mt_thread_scheduler.sv
// Directed self-checking bench for mt_thread_scheduler (perf counters exercised when MT_SCHED_PERF_EN is defined).
module tb_mt_thread_scheduler;
  import mt_pkg::*;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic [2*NUM_THREADS-1:0] thread_en;
  logic                     stall, wb_we, switch_req;
  logic                     switch_ack, issue_valid, tgrp, write_enable, wb_valid;
  logic [BITS_THREADS-1:0]  tid_read, tid_write;
  sched_state_t             state_dbg;
`ifdef MT_SCHED_PERF_EN
  logic                     perf_clr;
  logic [PERF_W-1:0]        issue_cnt, bubble_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mt_thread_scheduler #(.WB_LATENCY(3)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .thread_en    (thread_en),
    .stall        (stall),
    .wb_we        (wb_we),
    .switch_req   (switch_req),
    .switch_ack   (switch_ack),
    .issue_valid  (issue_valid),
    .tid_read     (tid_read),
    .tgrp         (tgrp),
    .tid_write    (tid_write),
    .write_enable (write_enable),
    .wb_valid     (wb_valid),
`ifdef MT_SCHED_PERF_EN
    .perf_clr     (perf_clr),
    .issue_cnt    (issue_cnt),
    .bubble_cnt   (bubble_cnt),
`endif
    .state_dbg    (state_dbg)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic to_check;
    @(negedge clk);
  endtask

  task automatic to_drive;
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench 1ns after a posedge with the slot counter at 0 (cycle 0)
  task automatic do_reset;
    rst_n = 1'b0;
    #1;
    check("rst_issue_valid", 32'(issue_valid), 32'd0);
    check("rst_wb_valid", 32'(wb_valid), 32'd0);
    check("rst_tid_read", 32'(tid_read), 32'd0);
    check("rst_tid_write", 32'(tid_write), 32'd0);
    check("rst_tgrp", 32'(tgrp), 32'd0);
    check("rst_switch_ack", 32'(switch_ack), 32'd0);
    check("rst_write_enable", 32'(write_enable), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    thread_en  = 8'hFF;
    stall      = 1'b0;
    wb_we      = 1'b1;
    switch_req = 1'b0;
`ifdef MT_SCHED_PERF_EN
    perf_clr   = 1'b0;
`endif

    // 1: all enabled, free-running slots, write-back 3 cycles behind
    do_reset();
    for (int c = 0; c < 12; c++) begin
      to_check();
      check("t1_tid_read", 32'(tid_read), 32'(c % 4));
      check("t1_issue_valid", 32'(issue_valid), 32'd1);
      check("t1_wb_valid", 32'(wb_valid), (c >= 3) ? 32'd1 : 32'd0);
      check("t1_tid_write", 32'(tid_write), (c >= 3) ? 32'((c - 3) % 4) : 32'd0);
      check("t1_write_enable", 32'(write_enable), (c >= 3) ? 32'd1 : 32'd0);
      if (c >= 3) check("t1_parity", 32'(tid_write[0] ^ tid_read[0]), 32'd1);
      to_drive();
    end

    // 2: only grp0 threads 0 and 2 enabled; wb_we dropped in cycle 7
    thread_en = 8'h05;
    do_reset();
    for (int c = 0; c < 10; c++) begin
      wb_we = (c == 7) ? 1'b0 : 1'b1;
      to_check();
      check("t2_issue_valid", 32'(issue_valid), (c % 2 == 0) ? 32'd1 : 32'd0);
      check("t2_wb_valid", 32'(wb_valid), (c >= 3 && c % 2 == 1) ? 32'd1 : 32'd0);
      check("t2_write_enable", 32'(write_enable), (c >= 3 && c % 2 == 1 && c != 7) ? 32'd1 : 32'd0);
      to_drive();
    end
    wb_we = 1'b1;

    // 3: stall in slots 1 and 2; counter keeps running
    thread_en = 8'hFF;
    do_reset();
    for (int c = 0; c < 8; c++) begin
      stall = (c == 1 || c == 2);
      to_check();
      check("t3_tid_read", 32'(tid_read), 32'(c % 4));
      check("t3_issue_valid", 32'(issue_valid), (c == 1 || c == 2) ? 32'd0 : 32'd1);
      check("t3_wb_valid", 32'(wb_valid), (c == 3 || c >= 6) ? 32'd1 : 32'd0);
      to_drive();
    end
    stall = 1'b0;

    // 4: switch pulse in cycle 5; drain, ack in cycle 9, group 1 has threads 0,1 only
    thread_en = 8'h3F;
    do_reset();
    for (int c = 0; c < 16; c++) begin
      switch_req = (c == 5);
      to_check();
      check("t4_issue_valid", 32'(issue_valid),
            (c < 5 || c == 12 || c == 13) ? 32'd1 : 32'd0);
      check("t4_wb_valid", 32'(wb_valid), ((c >= 3 && c <= 7) || c == 15) ? 32'd1 : 32'd0);
      check("t4_switch_ack", 32'(switch_ack), (c == 9) ? 32'd1 : 32'd0);
      check("t4_tgrp", 32'(tgrp), (c >= 10) ? 32'd1 : 32'd0);
      if (c == 6) check("t4_state_drain", 32'(state_dbg), 32'(DRAIN));
      if (c == 9) check("t4_state_switch", 32'(state_dbg), 32'(SWITCH));
      to_drive();
    end
    switch_req = 1'b0;

    // 5: reset asserted while draining
    thread_en = 8'hFF;
    do_reset();
    to_check();
    to_drive();
    switch_req = 1'b1;
    to_check();
    to_drive();
    switch_req = 1'b0;
    to_check();
    check("t5_state_drain", 32'(state_dbg), 32'(DRAIN));
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_async_issue", 32'(issue_valid), 32'd0);
    check("t5_async_wb_valid", 32'(wb_valid), 32'd0);
    check("t5_async_tid_read", 32'(tid_read), 32'd0);
    check("t5_async_state", 32'(state_dbg), 32'(RUN));
    check("t5_async_tgrp", 32'(tgrp), 32'd0);
    to_drive();
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      to_check();
      check("t5_switch_ack", 32'(switch_ack), 32'd0);
      check("t5_tgrp", 32'(tgrp), 32'd0);
      check("t5_issue_valid", 32'(issue_valid), 32'd1);
      to_drive();
    end

`ifdef MT_SCHED_PERF_EN
    // 6: 20 cycles, grp0 enabled, 4 stalled cycles, then clear
    thread_en = 8'h0F;
    do_reset();
    for (int c = 0; c < 20; c++) begin
      stall = (c >= 5 && c <= 8);
      to_drive();
    end
    stall = 1'b0;
    to_check();
    check("t6_issue_cnt", issue_cnt, 32'd16);
    check("t6_bubble_cnt", bubble_cnt, 32'd4);
    to_drive();
    perf_clr = 1'b1;
    to_drive();
    perf_clr = 1'b0;
    to_check();
    check("t6_issue_clr", issue_cnt, 32'd0);
    check("t6_bubble_clr", bubble_cnt, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
